// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle processor control unit:
// state encoding, opcodes, ALU codes, mux select codes and the control word.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      RTEXEC, IMMEX, ALUWB, BRANCH, JUMP, ERR
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_LUI  = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd4;
   localparam logic [2:0] ALU_PASS = 3'd7;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic       illegal;
      logic       err;
   } ctrl_t;

   // Successor of DECODE; FETCH means the opcode is not supported.
   function automatic state_t decode_next(logic [5:0] op);
      case (op)
         OP_LW, OP_SW:           return MEMADR;
         OP_RTYPE:               return RTEXEC;
         OP_ADDI, OP_ORI, OP_LUI: return IMMEX;
         OP_BGTZ:                return BRANCH;
         OP_J:                   return JUMP;
         default:                return FETCH;
      endcase
   endfunction

   function automatic logic is_wait_state(state_t s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

endpackage

// File: rtl/mc_out_dec.sv
// Combinational control-word decode from the current state, opcode and the
// two input flags that some states react to within the same cycle.
module mc_out_dec
   import mc_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  op,
   input  logic        gtz,
   input  logic        mem_ready,
   output ctrl_t       ctrl
);

   always_comb begin
      // NOTE: every field gets a default before the case so no path leaves one unassigned (no latch).
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.mem_read    = 1'b1;
            ctrl.alu_src_b   = SRCB_FOUR;
            ctrl.alu_control = ALU_ADD;
            ctrl.pc_src      = PC_ALU;
            ctrl.ir_write    = mem_ready;
            ctrl.pc_write    = mem_ready;
         end
         DECODE: begin
            ctrl.alu_src_b   = SRCB_IMM_SH;
            ctrl.alu_control = ALU_ADD;
            ctrl.illegal     = (decode_next(op) == FETCH);
         end
         MEMADR: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_IMM;
            ctrl.alu_control = ALU_ADD;
         end
         MEMRD: begin
            ctrl.iord     = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         MEMWR: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         RTEXEC: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_RT;
            ctrl.alu_control = ALU_ADD;
         end
         IMMEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            case (op)
               OP_ORI:  ctrl.alu_control = ALU_OR;
               OP_LUI:  ctrl.alu_control = ALU_LUI;
               default: ctrl.alu_control = ALU_ADD;
            endcase
         end
         ALUWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = (op == OP_RTYPE);
         end
         BRANCH: begin
            ctrl.pc_src   = PC_ALUOUT;
            ctrl.pc_write = gtz;
         end
         JUMP: begin
            ctrl.pc_src      = PC_JUMP;
            ctrl.pc_write    = 1'b1;
            ctrl.alu_control = ALU_PASS;
         end
         ERR:     ctrl.err = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle processor control unit: state register, next-state logic and a
// memory wait watchdog that parks the machine in ERR until reset.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       gtz,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic       illegal,
   output logic       err
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic          waiting, timeout;
   state_t        dec_state;
   logic          dec_ready;
   ctrl_t         ctrl;

   assign waiting = is_wait_state(state) && !mem_ready;
   assign timeout = waiting && (wait_cnt == CW'(WAIT_LIMIT - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   if (mem_ready) state_nxt = DECODE;
         DECODE:  state_nxt = decode_next(op);
         MEMADR:  state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   if (mem_ready) state_nxt = MEMWB;
         MEMWR:   if (mem_ready) state_nxt = FETCH;
         RTEXEC,
         IMMEX:   state_nxt = ALUWB;
         MEMWB,
         ALUWB,
         BRANCH,
         JUMP:    state_nxt = FETCH;
         ERR:     state_nxt = ERR;
         default: state_nxt = FETCH;
      endcase
      // A ready in the final allowed cycle has already advanced state_nxt above.
      if (timeout) state_nxt = ERR;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         state    <= FETCH;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= (waiting && state_nxt == state) ? wait_cnt + 1'b1 : '0;
      end
   end

   // While reset is asserted the outputs already show FETCH, minus the loads.
   assign dec_state = rst_n ? state : FETCH;
   assign dec_ready = rst_n & mem_ready;

   mc_out_dec u_out_dec (
      .state     (dec_state),
      .op        (op),
      .gtz       (gtz),
      .mem_ready (dec_ready),
      .ctrl      (ctrl)
   );

   assign pc_write    = ctrl.pc_write;
   assign pc_src      = ctrl.pc_src;
   assign iord        = ctrl.iord;
   assign mem_read    = ctrl.mem_read;
   assign mem_write   = ctrl.mem_write;
   assign ir_write    = ctrl.ir_write;
   assign reg_dst     = ctrl.reg_dst;
   assign mem_to_reg  = ctrl.mem_to_reg;
   assign reg_write   = ctrl.reg_write;
   assign alu_src_a   = ctrl.alu_src_a;
   assign alu_src_b   = ctrl.alu_src_b;
   assign alu_control = ctrl.alu_control;
   assign illegal     = ctrl.illegal;
   assign err         = ctrl.err;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: a per-cycle vector table of instruction
// sequences, then hand-written reset and wait-limit corner sequences.
module tb_mc_ctrl;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic       illegal;
      logic       err;
   } outs_t;

   typedef struct {
      string      name;
      logic       rst_n;
      logic [5:0] op;
      logic       gtz;
      logic       rdy;
      outs_t      exp;
   } vec_t;

   localparam logic [5:0] ADD  = 6'b000000;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] ORI  = 6'b001101;
   localparam logic [5:0] LUI  = 6'b001111;
   localparam logic [5:0] BGTZ = 6'b000111;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;

   logic       clk = 1'b0;
   logic       rst_n, gtz, mem_ready;
   logic [5:0] op;
   logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
   logic       mem_to_reg, reg_write, alu_src_a, illegal, err;
   logic [1:0] pc_src, alu_src_b;
   logic [2:0] alu_control;
   outs_t      got;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mc_ctrl #(.WAIT_LIMIT(15)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .gtz(gtz), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_control(alu_control), .illegal(illegal),
      .err(err)
   );

   assign got = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control,
                 illegal, err};

   // Expected control words, written out field by field for each state.
   function automatic outs_t o_fetch(logic r);
      outs_t o = '0;
      o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_control = 3'd1;
      o.ir_write = r; o.pc_write = r;
      return o;
   endfunction
   function automatic outs_t o_decode(logic ill);
      outs_t o = '0;
      o.alu_src_b = 2'b11; o.alu_control = 3'd1; o.illegal = ill;
      return o;
   endfunction
   function automatic outs_t o_memadr();
      outs_t o = '0;
      o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'd1;
      return o;
   endfunction
   function automatic outs_t o_memrd();
      outs_t o = '0;
      o.iord = 1; o.mem_read = 1;
      return o;
   endfunction
   function automatic outs_t o_memwb();
      outs_t o = '0;
      o.mem_to_reg = 1; o.reg_write = 1;
      return o;
   endfunction
   function automatic outs_t o_memwr();
      outs_t o = '0;
      o.iord = 1; o.mem_write = 1;
      return o;
   endfunction
   function automatic outs_t o_rtexec();
      outs_t o = '0;
      o.alu_src_a = 1; o.alu_src_b = 2'b00; o.alu_control = 3'd1;
      return o;
   endfunction
   function automatic outs_t o_immex(logic [2:0] c);
      outs_t o = '0;
      o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = c;
      return o;
   endfunction
   function automatic outs_t o_aluwb(logic rd);
      outs_t o = '0;
      o.reg_write = 1; o.reg_dst = rd;
      return o;
   endfunction
   function automatic outs_t o_branch(logic g);
      outs_t o = '0;
      o.pc_src = 2'b01; o.pc_write = g;
      return o;
   endfunction
   function automatic outs_t o_jump();
      outs_t o = '0;
      o.pc_src = 2'b10; o.pc_write = 1; o.alu_control = 3'd7;
      return o;
   endfunction
   function automatic outs_t o_err();
      outs_t o = '0;
      o.err = 1;
      return o;
   endfunction

   task automatic add(input string n, input logic rs, input logic [5:0] o,
                      input logic g, input logic r, input outs_t e);
      vec_t v;
      v.name = n; v.rst_n = rs; v.op = o; v.gtz = g; v.rdy = r; v.exp = e;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs at the falling edge, then check the outputs.
   task automatic cyc(input string n, input logic rs, input logic [5:0] o,
                      input logic g, input logic r, input outs_t e);
      @(negedge clk);
      rst_n = rs; op = o; gtz = g; mem_ready = r;
      #1;
      checks++;
      if (got !== e) begin
         failures++;
         $display("FAIL %s at t=%0t: got=%h expected=%h", n, $time, got, e);
      end
   endtask

   initial begin
      rst_n = 1'b0; op = ADD; gtz = 1'b0; mem_ready = 1'b0;

      // Reset, with mem_ready high to show the loads stay off.
      add("reset0", 0, ADD, 0, 1, o_fetch(0));
      add("reset1", 0, ADD, 0, 1, o_fetch(0));
      // ADD with mem_ready high throughout.
      add("add_fetch",  1, ADD, 0, 1, o_fetch(1));
      add("add_decode", 1, ADD, 0, 1, o_decode(0));
      add("add_rtexec", 1, ADD, 0, 1, o_rtexec());
      add("add_aluwb",  1, ADD, 0, 1, o_aluwb(1));
      // Immediate ops.
      add("addi_fetch",  1, ADDI, 0, 1, o_fetch(1));
      add("addi_decode", 1, ADDI, 0, 1, o_decode(0));
      add("addi_immex",  1, ADDI, 0, 1, o_immex(3'd1));
      add("addi_aluwb",  1, ADDI, 0, 1, o_aluwb(0));
      add("ori_fetch",   1, ORI, 0, 1, o_fetch(1));
      add("ori_decode",  1, ORI, 0, 1, o_decode(0));
      add("ori_immex",   1, ORI, 0, 1, o_immex(3'd4));
      add("ori_aluwb",   1, ORI, 0, 1, o_aluwb(0));
      add("lui_fetch",   1, LUI, 0, 1, o_fetch(1));
      add("lui_decode",  1, LUI, 0, 1, o_decode(0));
      add("lui_immex",   1, LUI, 0, 1, o_immex(3'd0));
      add("lui_aluwb",   1, LUI, 0, 1, o_aluwb(0));
      // LW with three MEMRD wait cycles: eight cycles in total.
      add("lw_fetch",  1, LW, 0, 1, o_fetch(1));
      add("lw_decode", 1, LW, 0, 1, o_decode(0));
      add("lw_memadr", 1, LW, 0, 1, o_memadr());
      for (int i = 0; i < 3; i++) add("lw_memrd_wait", 1, LW, 0, 0, o_memrd());
      add("lw_memrd_done", 1, LW, 0, 1, o_memrd());
      add("lw_memwb",      1, LW, 0, 1, o_memwb());
      // SW, zero wait.
      add("sw_fetch",  1, SW, 0, 1, o_fetch(1));
      add("sw_decode", 1, SW, 0, 1, o_decode(0));
      add("sw_memadr", 1, SW, 0, 1, o_memadr());
      add("sw_memwr",  1, SW, 0, 1, o_memwr());
      // BGTZ not taken, then taken.
      add("bgtz0_fetch",  1, BGTZ, 0, 1, o_fetch(1));
      add("bgtz0_decode", 1, BGTZ, 0, 1, o_decode(0));
      add("bgtz0_branch", 1, BGTZ, 0, 1, o_branch(0));
      add("bgtz1_fetch",  1, BGTZ, 1, 1, o_fetch(1));
      add("bgtz1_decode", 1, BGTZ, 1, 1, o_decode(0));
      add("bgtz1_branch", 1, BGTZ, 1, 1, o_branch(1));
      // Jump.
      add("j_fetch",  1, JMP, 0, 1, o_fetch(1));
      add("j_decode", 1, JMP, 0, 1, o_decode(0));
      add("j_jump",   1, JMP, 0, 1, o_jump());
      // Unsupported opcode: one-cycle illegal, straight back to FETCH.
      add("ill_fetch",  1, BAD, 0, 1, o_fetch(1));
      add("ill_decode", 1, BAD, 0, 1, o_decode(1));
      add("ill_back",   1, BAD, 0, 0, o_fetch(0));
      // 10 waits in FETCH then 10 in MEMRD: the counter must clear in between.
      for (int i = 0; i < 9; i++) add("lw2_fetch_wait", 1, LW, 0, 0, o_fetch(0));
      add("lw2_fetch",  1, LW, 0, 1, o_fetch(1));
      add("lw2_decode", 1, LW, 0, 1, o_decode(0));
      add("lw2_memadr", 1, LW, 0, 1, o_memadr());
      for (int i = 0; i < 10; i++) add("lw2_memrd_wait", 1, LW, 0, 0, o_memrd());
      add("lw2_memrd_done", 1, LW, 0, 1, o_memrd());
      add("lw2_memwb",      1, LW, 0, 1, o_memwb());

      foreach (vecs[i])
         cyc(vecs[i].name, vecs[i].rst_n, vecs[i].op, vecs[i].gtz, vecs[i].rdy, vecs[i].exp);

      // Reset in the middle of a stalled store abandons the write.
      cyc("rsw_fetch",  1, SW, 0, 1, o_fetch(1));
      cyc("rsw_decode", 1, SW, 0, 1, o_decode(0));
      cyc("rsw_memadr", 1, SW, 0, 1, o_memadr());
      cyc("rsw_memwr0", 1, SW, 0, 0, o_memwr());
      cyc("rsw_memwr1", 1, SW, 0, 0, o_memwr());
      cyc("rsw_in_rst", 0, SW, 0, 0, o_fetch(0));
      cyc("rsw_after",  1, SW, 0, 0, o_fetch(0));

      // Ready in the WAIT_LIMIT-th cycle wins over the timeout.
      cyc("lim_fetch",  1, SW, 0, 1, o_fetch(1));
      cyc("lim_decode", 1, SW, 0, 1, o_decode(0));
      cyc("lim_memadr", 1, SW, 0, 1, o_memadr());
      for (int i = 0; i < 14; i++) cyc("lim_memwr_wait", 1, SW, 0, 0, o_memwr());
      cyc("lim_memwr_ready", 1, SW, 0, 1, o_memwr());
      cyc("lim_back_fetch",  1, SW, 0, 0, o_fetch(0));

      // Fifteen stalled MEMWR cycles time out into sticky ERR.
      cyc("to_fetch",  1, SW, 0, 1, o_fetch(1));
      cyc("to_decode", 1, SW, 0, 1, o_decode(0));
      cyc("to_memadr", 1, SW, 0, 1, o_memadr());
      for (int i = 0; i < 15; i++) cyc("to_memwr_wait", 1, SW, 0, 0, o_memwr());
      cyc("to_err0", 1, SW,  0, 1, o_err());
      cyc("to_err1", 1, ADD, 1, 1, o_err());
      cyc("to_err2", 1, BAD, 0, 0, o_err());
      cyc("to_err_in_rst", 0, ADD, 0, 0, o_fetch(0));
      cyc("to_after_rst",  1, ADD, 0, 1, o_fetch(1));
      cyc("to_decode2",    1, ADD, 0, 1, o_decode(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
